button_debounce: RTL and testbench



---
 rtl/button_debounce_pkg.sv | 25 ++
 rtl/button_debounce_sync_ff.sv | 33 +++
 rtl/button_debounce.sv | 180 ++++++++++++++++++
 tb/tb_button_debounce.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared button definitions: FSM encodings, width helper and 25 MHz timing defaults.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEF_SYNC_STAGES       = 2;
    localparam int DEF_DEBOUNCE_CYCLES   = 250000;
    localparam int DEF_LONG_PRESS_CYCLES = 25000000;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2_w(input int value);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/button_debounce_sync_ff.sv
// Multi-stage synchronizer for an asynchronous pin; reset loads a chosen idle level.
module sync_ff
    import button_debounce_pkg::*;
#(
    parameter int   STAGES    = DEF_SYNC_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk0,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the pin one stage deeper each cycle.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_in};
    end

    // Chain registers with synchronous active-low reset.
    always_ff @(posedge clk0) begin
        if (!rst) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_out = chain_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw button pin into a clean level plus press, release and long-press strobes,
// a press-toggle level and a wrapping press counter.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int ACTIVE_LOW        = 1
) (
    input  logic       clk0,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       toggle,
    output logic [7:0] press_count
);

    localparam int                DEB_W     = clog2_w(DEBOUNCE_CYCLES);
    localparam int                HOLD_W    = clog2_w(LONG_PRESS_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic              POLARITY  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic sync_s;
    logic pressed_s;

    btn_state_e        state_q,     state_d;
    logic [DEB_W-1:0]  deb_cnt_q,   deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic              long_done_q, long_done_d;
    logic              level_q,     level_d;
    logic              press_q,     press_d;
    logic              release_q,   release_d;
    logic              long_q,      long_d;
    logic              toggle_q,    toggle_d;
    logic [7:0]        count_q,     count_d;

    logic [HOLD_W-1:0] hold_adv_s;
    logic              long_due_s;

    // The released pin level is the synchronizer's reset value, so reset never looks like a press.
    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (POLARITY)
    ) u_sync (
        .clk0  (clk0),
        .rst   (rst),
        .d_in  (btn_in),
        .q_out (sync_s)
    );

    assign pressed_s = sync_s ^ POLARITY;

    // Saturating hold counter and one-shot long-press detection shared by both held states.
    always_comb begin
        if (hold_cnt_q == HOLD_LAST) begin
            hold_adv_s = hold_cnt_q;
        end else begin
            hold_adv_s = hold_cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
        long_due_s = (hold_cnt_q == HOLD_LAST) && !long_done_q;
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        toggle_d    = toggle_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (pressed_s) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    toggle_d    = ~toggle_q;
                    count_d     = count_q + 8'd1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + {{(DEB_W-1){1'b0}}, 1'b1};
                end
            end
            PRESSED: begin
                hold_cnt_d = hold_adv_s;
                if (long_due_s) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end else begin
                    long_d = 1'b0;
                end
                if (!pressed_s) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end else begin
                    state_d = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                // The accepting cycle suppresses long_pulse so it never meets its own release.
                if (!pressed_s && (deb_cnt_q == DEB_LAST)) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_adv_s;
                    if (long_due_s) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        long_d = 1'b0;
                    end
                    if (pressed_s) begin
                        state_d = PRESSED;
                    end else begin
                        deb_cnt_d = deb_cnt_q + {{(DEB_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk0) begin
        if (!rst) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            toggle_q    <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            toggle_q    <= toggle_d;
            count_q     <= count_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign toggle        = toggle_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench: a run-length reference model predicts pulse events, a monitor checks them.
module tb_button_debounce;

    localparam int DEB   = 4;
    localparam int LONGC = 20;
    localparam bit AL    = 1'b1;

    logic       clk0 = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b1;
    logic       btn_level, press_pulse, release_pulse, long_pulse, toggle;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [2:0] pulses;
        logic       level;
        logic       tog;
        logic [7:0] cnt;
    } exp_t;
    exp_t sbq[$];

    bit       sq[$];
    bit       lvl_m, tog_m;
    bit [7:0] cnt_m;
    int       run_m, hold_m;

    button_debounce #(
        .SYNC_STAGES       (2),
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONGC),
        .ACTIVE_LOW        (1)
    ) dut (
        .clk0          (clk0),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .toggle        (toggle),
        .press_count   (press_count)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        sq.delete();
        sq.push_back(1'b0);
        sq.push_back(1'b0);
        lvl_m  = 1'b0;
        tog_m  = 1'b0;
        cnt_m  = 8'd0;
        run_m  = 0;
        hold_m = 0;
    endfunction

    // A change is accepted once the synchronized input has differed from the accepted level
    // for DEB+1 consecutive edges; a long press is LONGC edges after acceptance.
    function automatic void model_edge(input bit b);
        bit         s;
        bit         acc;
        logic [2:0] pul;
        exp_t       e;
        sq.push_back(b ^ AL);
        s   = sq.pop_front();
        acc = 1'b0;
        pul = 3'b000;
        if (s != lvl_m) run_m++;
        else run_m = 0;
        if (run_m == DEB + 1) begin
            acc   = 1'b1;
            run_m = 0;
        end
        if (lvl_m) begin
            hold_m++;
            if (!acc && hold_m == LONGC) pul[0] = 1'b1;
        end
        if (acc) begin
            lvl_m = !lvl_m;
            if (lvl_m) begin
                pul[2] = 1'b1;
                tog_m  = !tog_m;
                cnt_m  = cnt_m + 8'd1;
                hold_m = 0;
            end else begin
                pul[1] = 1'b1;
            end
        end
        if (pul != 3'b000) begin
            e.cyc    = cyc + 1;
            e.pulses = pul;
            e.level  = lvl_m;
            e.tog    = tog_m;
            e.cnt    = cnt_m;
            sbq.push_back(e);
        end
    endfunction

    task automatic step(input bit b);
        @(negedge clk0);
        rst    = 1'b1;
        btn_in = b;
        model_edge(b);
    endtask

    task automatic hold(input bit b, input int n);
        repeat (n) step(b);
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk0);
            rst    = 1'b0;
            btn_in = 1'($urandom_range(0, 1));
            model_reset();
            @(posedge clk0);
            #1;
            check("reset_outputs", {btn_level, press_pulse, release_pulse, long_pulse, toggle, press_count}, 32'd0);
        end
    endtask

    // Monitor: compares DUT pulses against the scoreboard on every non-reset edge.
    initial begin
        logic r;
        exp_t e;
        forever begin
            @(posedge clk0);
            r = rst;
            #1;
            if (r) begin
                while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                    e = sbq.pop_front();
                    check("missed_event", 32'(e.cyc), 32'(cyc));
                end
                if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                    e = sbq.pop_front();
                    check("pulses", {29'd0, press_pulse, release_pulse, long_pulse}, {29'd0, e.pulses});
                    check("event_state", {22'd0, btn_level, toggle, press_count}, {22'd0, e.level, e.tog, e.cnt});
                end else begin
                    check("no_pulse", {29'd0, press_pulse, release_pulse, long_pulse}, 32'd0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset(3);
        step(1'b1);
        @(posedge clk0);
        #1;
        check("after_reset", {btn_level, press_pulse, release_pulse, long_pulse, toggle, press_count}, 32'd0);
        hold(1'b1, 5);

        // Clean press then release
        hold(1'b0, 12);
        check("clean_level", {31'd0, btn_level}, 32'd1);
        check("clean_count", {24'd0, press_count}, 32'd1);
        check("clean_toggle", {31'd0, toggle}, 32'd1);
        hold(1'b1, 12);
        check("clean_released", {31'd0, btn_level}, 32'd0);

        // Bounce rejection
        hold(1'b0, 3);
        hold(1'b1, 2);
        hold(1'b0, 3);
        hold(1'b1, 10);
        check("bounce_count", {24'd0, press_count}, 32'd1);
        check("bounce_level", {31'd0, btn_level}, 32'd0);

        // Long press and release
        hold(1'b0, 47);
        hold(1'b1, 12);
        check("long_released", {31'd0, btn_level}, 32'd0);

        // Release glitch during a long hold
        hold(1'b0, 10);
        hold(1'b1, 2);
        hold(1'b0, 25);
        check("glitch_level", {31'd0, btn_level}, 32'd1);
        hold(1'b1, 12);

        // Counter wrap over 256 presses
        do_reset(2);
        for (int i = 0; i < 256; i++) begin
            hold(1'b0, 6);
            hold(1'b1, 6);
        end
        check("wrap_count", {24'd0, press_count}, 32'd0);
        check("wrap_toggle", {31'd0, toggle}, 32'd0);

        // Reset while a press is still being debounced
        hold(1'b0, 4);
        do_reset(1);
        hold(1'b1, 10);
        check("abort_level", {31'd0, btn_level}, 32'd0);
        check("abort_count", {24'd0, press_count}, 32'd0);

        // Randomized bouncing and holds
        for (int i = 0; i < 150; i++) begin
            int n;
            if ($urandom_range(0, 3) == 0) n = int'($urandom_range(15, 40));
            else n = int'($urandom_range(1, 8));
            hold(1'($urandom_range(0, 1)), n);
        end
        hold(1'b1, 15);
        @(posedge clk0);
        #2;
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        check("final_state", {22'd0, btn_level, toggle, press_count}, {22'd0, lvl_m, tog_m, cnt_m});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
